// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer.
//   - seq_state_e : sequencer FSM states (3-bit encoding)
//   - clog2       : ceiling log2, used to size the stage index / fail_stage
//   - DEF_*       : default parameter values for the sequencer
package rst_seq_pkg;

    typedef enum logic [2:0] {
        HOLD  = 3'd0,   // all stage resets held low, hold timer running
        DELAY = 3'd1,   // inter-stage delay before releasing stage idx
        WAIT  = 3'd2,   // stage idx released, waiting for its ready/lock
        DONE  = 3'd3,   // every stage released and ready
        ERROR = 3'd4    // a stage timed out; everything held in reset
    } seq_state_e;

    localparam int DEF_NUM_STAGES    = 4;
    localparam int DEF_HOLD_CYCLES   = 16;
    localparam int DEF_STAGE_DELAY   = 1000;
    localparam int DEF_READY_TIMEOUT = 65535;
    localparam int DEF_CNT_W         = 16;

    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter used for the hold, inter-stage delay and ready
// timeout intervals.
// Ports:
//   clk      in  system clock
//   rst      in  synchronous active-high reset, counter takes RST_VAL
//   load     in  load load_val (has priority over en)
//   load_val in  CNT_W value to load
//   en       in  decrement by one; saturates at zero, never wraps
//   zero     out counter is zero
module seq_timer #(
    parameter int               CNT_W   = 16,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= RST_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/reset_sequencer.sv
// Power-up reset sequencer: holds every downstream reset domain in reset,
// then releases them one at a time (bit 0 first), waiting for each stage's
// ready/lock before the next inter-stage delay starts. A stage that never
// reports ready within READY_TIMEOUT cycles parks the block in ERROR with
// all resets asserted. Loss of any ready bit once DONE restarts the sequence.
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   sw_reset_req in   single-cycle request to restart the whole sequence
//   stage_ready  in   per-stage ready/lock, already synchronous to clk
//   stage_rst_n  out  per-stage active-low reset (registered)
//   all_released out  every stage released and ready (registered)
//   timeout_err  out  sticky timeout flag (registered)
//   fail_stage   out  index of the stage that timed out (registered)
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NUM_STAGES    = DEF_NUM_STAGES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int STAGE_DELAY   = DEF_STAGE_DELAY,
    parameter int READY_TIMEOUT = DEF_READY_TIMEOUT,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sw_reset_req,
    input  logic [NUM_STAGES-1:0] stage_ready,
    output logic [NUM_STAGES-1:0] stage_rst_n,
    output logic                  all_released,
    output logic                  timeout_err,
    output logic [((NUM_STAGES > 1) ? clog2(NUM_STAGES) : 1)-1:0] fail_stage
);

    localparam int IDX_W = (NUM_STAGES > 1) ? clog2(NUM_STAGES) : 1;

    localparam logic [CNT_W-1:0] HOLD_LOAD    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LOAD   = CNT_W'(STAGE_DELAY - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(READY_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_STAGES - 1);

    seq_state_e            state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_STAGES-1:0] stage_rst_n_q, stage_rst_n_d;
    logic                  all_released_q, all_released_d;
    logic                  timeout_err_q, timeout_err_d;
    logic [IDX_W-1:0]      fail_stage_q, fail_stage_d;

    logic                  tmr_load;
    logic [CNT_W-1:0]      tmr_load_val;
    logic                  tmr_en;
    logic                  tmr_zero;

    // The timer resets straight to the hold interval so HOLD counts from the
    // first clean cycle without an extra load cycle.
    seq_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (HOLD_LOAD)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .en       (tmr_en),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        stage_rst_n_d  = stage_rst_n_q;
        all_released_d = all_released_q;
        timeout_err_d  = timeout_err_q;
        fail_stage_d   = fail_stage_q;
        tmr_load       = 1'b0;
        tmr_load_val   = '0;
        tmr_en         = 1'b0;

        if (sw_reset_req) begin
            // Software restart overrides every other transition.
            state_d        = HOLD;
            idx_d          = '0;
            stage_rst_n_d  = '0;
            all_released_d = 1'b0;
            timeout_err_d  = 1'b0;
            fail_stage_d   = '0;
            tmr_load       = 1'b1;
            tmr_load_val   = HOLD_LOAD;
        end else begin
            case (state_q)
                HOLD: begin
                    stage_rst_n_d = '0;
                    if (tmr_zero) begin
                        state_d      = DELAY;
                        tmr_load     = 1'b1;
                        tmr_load_val = DELAY_LOAD;
                    end else begin
                        tmr_en = 1'b1;
                    end
                end

                DELAY: begin
                    if (tmr_zero) begin
                        stage_rst_n_d[idx_q] = 1'b1;
                        state_d              = WAIT;
                        tmr_load             = 1'b1;
                        tmr_load_val         = TIMEOUT_LOAD;
                    end else begin
                        tmr_en = 1'b1;
                    end
                end

                WAIT: begin
                    // Ready wins over an expiring timer on the same cycle.
                    if (stage_ready[idx_q]) begin
                        if (idx_q == LAST_IDX) begin
                            state_d        = DONE;
                            all_released_d = 1'b1;
                        end else begin
                            idx_d        = idx_q + IDX_W'(1);
                            state_d      = DELAY;
                            tmr_load     = 1'b1;
                            tmr_load_val = DELAY_LOAD;
                        end
                    end else if (tmr_zero) begin
                        state_d        = ERROR;
                        timeout_err_d  = 1'b1;
                        fail_stage_d   = idx_q;
                        stage_rst_n_d  = '0;
                        all_released_d = 1'b0;
                    end else begin
                        tmr_en = 1'b1;
                    end
                end

                DONE: begin
                    // Any ready loss tears everything down on one edge.
                    if (stage_ready != {NUM_STAGES{1'b1}}) begin
                        state_d        = HOLD;
                        idx_d          = '0;
                        stage_rst_n_d  = '0;
                        all_released_d = 1'b0;
                        tmr_load       = 1'b1;
                        tmr_load_val   = HOLD_LOAD;
                    end
                end

                ERROR: begin
                    stage_rst_n_d  = '0;
                    all_released_d = 1'b0;
                end

                default: begin
                    state_d        = HOLD;
                    idx_d          = '0;
                    stage_rst_n_d  = '0;
                    all_released_d = 1'b0;
                    tmr_load       = 1'b1;
                    tmr_load_val   = HOLD_LOAD;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= HOLD;
            idx_q          <= '0;
            stage_rst_n_q  <= '0;
            all_released_q <= 1'b0;
            timeout_err_q  <= 1'b0;
            fail_stage_q   <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            stage_rst_n_q  <= stage_rst_n_d;
            all_released_q <= all_released_d;
            timeout_err_q  <= timeout_err_d;
            fail_stage_q   <= fail_stage_d;
        end
    end

    assign stage_rst_n  = stage_rst_n_q;
    assign all_released = all_released_q;
    assign timeout_err  = timeout_err_q;
    assign fail_stage   = fail_stage_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer (3 stages, hold 4, delay 8, timeout 16).
// The reference model tracks absolute edge numbers at which the next release
// or timeout is due, rather than stepping a countdown per state.
module tb_reset_sequencer;

    localparam int NS = 3;
    localparam int H  = 4;
    localparam int D  = 8;
    localparam int T  = 16;
    localparam int CW = 16;
    localparam int IW = 2;

    localparam int P_COUNT = 0;   // counting towards the next release edge
    localparam int P_WAIT  = 1;   // stage released, waiting for its ready
    localparam int P_DONE  = 2;
    localparam int P_ERR   = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          sw_reset_req;
    logic [NS-1:0] stage_ready;
    logic [NS-1:0] stage_rst_n;
    logic          all_released;
    logic          timeout_err;
    logic [IW-1:0] fail_stage;

    always #5 clk = ~clk;

    reset_sequencer #(
        .NUM_STAGES    (NS),
        .HOLD_CYCLES   (H),
        .STAGE_DELAY   (D),
        .READY_TIMEOUT (T),
        .CNT_W         (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sw_reset_req (sw_reset_req),
        .stage_ready  (stage_ready),
        .stage_rst_n  (stage_rst_n),
        .all_released (all_released),
        .timeout_err  (timeout_err),
        .fail_stage   (fail_stage)
    );

    int vectors    = 0;
    int miscompares = 0;

    // reference model
    int            m_edge = 0;
    int            m_phase;
    int            m_idx;
    int            m_rel_edge;
    logic [NS-1:0] m_rst_n;
    logic          m_all;
    logic          m_err;
    logic [IW-1:0] m_fail;

    // stimulus control
    bit            tie_ready;
    logic [NS-1:0] ready_mask;
    logic [NS-1:0] free_ready;
    logic [NS-1:0] rst_hist;

    task automatic model_restart();
        m_phase    = P_COUNT;
        m_idx      = 0;
        m_rel_edge = m_edge + H + D;
        m_rst_n    = '0;
        m_all      = 1'b0;
    endtask

    task automatic model_edge(input logic r, input logic s, input logic [NS-1:0] rdy);
        m_edge++;
        if (r || s) begin
            model_restart();
            m_err  = 1'b0;
            m_fail = '0;
        end else begin
            case (m_phase)
                P_COUNT: begin
                    if (m_edge == m_rel_edge) begin
                        m_rst_n[m_idx] = 1'b1;
                        m_phase        = P_WAIT;
                    end
                end
                P_WAIT: begin
                    if (rdy[m_idx]) begin
                        if (m_idx == NS - 1) begin
                            m_phase = P_DONE;
                            m_all   = 1'b1;
                        end else begin
                            m_idx      = m_idx + 1;
                            m_phase    = P_COUNT;
                            m_rel_edge = m_edge + D;
                        end
                    end else if (m_edge == m_rel_edge + T) begin
                        m_phase = P_ERR;
                        m_err   = 1'b1;
                        m_fail  = IW'(m_idx);
                        m_rst_n = '0;
                        m_all   = 1'b0;
                    end
                end
                P_DONE: begin
                    if (rdy != {NS{1'b1}}) model_restart();
                end
                default: ;
            endcase
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, m_edge);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(rst, sw_reset_req, stage_ready);
        #1;
        check("stage_rst_n",  32'(stage_rst_n),  32'(m_rst_n));
        check("all_released", 32'(all_released), 32'(m_all));
        check("timeout_err",  32'(timeout_err),  32'(m_err));
        check("fail_stage",   32'(fail_stage),   32'(m_fail));
        // ready follows the reset outputs two cycles late, or a free pattern
        if (tie_ready) begin
            stage_ready = rst_hist & ready_mask;
        end else begin
            stage_ready = free_ready;
        end
        rst_hist = stage_rst_n;
    endtask

    task automatic sw_pulse();
        sw_reset_req = 1'b1;
        step();
        sw_reset_req = 1'b0;
    endtask

    task automatic run_until_rst_n(input logic [NS-1:0] pat, input int limit);
        int n;
        n = 0;
        while (stage_rst_n !== pat && n < limit) begin
            step();
            n++;
        end
        vectors++;
        assert (stage_rst_n === pat) else begin
            miscompares++;
            $error("FAIL wait_rst_n: observed %b expected %b within %0d cycles", stage_rst_n, pat, limit);
        end
    endtask

    initial begin
        rst          = 1'b1;
        sw_reset_req = 1'b0;
        stage_ready  = '0;
        tie_ready    = 1'b1;
        ready_mask   = '1;
        free_ready   = '0;
        rst_hist     = '0;

        // nominal power-up
        repeat (3) step();
        rst = 1'b0;
        repeat (70) step();
        check("nominal_all_released", 32'(all_released), 32'd1);

        // ready loss while DONE
        ready_mask = 3'b110;
        step();
        ready_mask = '1;
        step();
        check("ready_loss_rst_n", 32'(stage_rst_n), 32'd0);
        repeat (70) step();
        check("ready_loss_recovered", 32'(all_released), 32'd1);

        // timeout on stage 1
        ready_mask = 3'b101;
        sw_pulse();
        repeat (70) step();
        check("timeout_err_set", 32'(timeout_err), 32'd1);
        check("timeout_fail_stage", 32'(fail_stage), 32'd1);

        // recovery through software request
        ready_mask = '1;
        sw_pulse();
        check("recovery_err_clear", 32'(timeout_err), 32'd0);
        repeat (70) step();
        check("recovery_all_released", 32'(all_released), 32'd1);

        // software restart during the stage 2 delay
        sw_pulse();
        run_until_rst_n(3'b011, 80);
        repeat (4) step();
        sw_pulse();
        check("mid_restart_rst_n", 32'(stage_rst_n), 32'd0);
        repeat (40) step();

        // rst while stage 1 is waiting for ready
        ready_mask = 3'b101;
        sw_pulse();
        run_until_rst_n(3'b011, 80);
        repeat (3) step();
        rst = 1'b1;
        repeat (3) step();
        check("rst_in_wait_rst_n", 32'(stage_rst_n), 32'd0);
        rst        = 1'b0;
        ready_mask = '1;
        repeat (70) step();

        // randomized traffic
        for (int i = 0; i < 2500; i++) begin
            sw_reset_req = ($urandom_range(0, 79) == 0);
            rst          = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 29) == 0) begin
                tie_ready  = ($urandom_range(0, 3) != 0);
                ready_mask = ($urandom_range(0, 2) == 0) ? NS'($urandom) : {NS{1'b1}};
                free_ready = NS'($urandom);
            end
            step();
        end

        sw_reset_req = 1'b0;
        rst          = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
